alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_op  input  2  main-decoder class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
REQ-005 funct  input  6  R-type function field.
REQ-006 rs_data, rt_data  input  WIDTH each  register-file operands.
REQ-007 flush  input  1  drop all buffered work.
REQ-008 in_valid  input  1  / in_ready  output  1  upstream handshake.
REQ-009 out_valid  output  1  / out_ready  input  1  downstream (ALU) handshake.
REQ-010 opcode  output  4  ALU operation code.
REQ-011 a, b  output  WIDTH each  ALU operands.
REQ-012 illegal  output  1  entry carried an undecodable alu_op/funct.

Function
REQ-013 Decode SHALL map: alu_op 00 -> 0000 (add); 01 -> 0010 (sub); 10 with funct 100000/100010/100100/100101/100110/100111/101010 -> 0000/0010/0100/0101/0110/0111/1010 (add/sub/and/or/xor/nor/slt).
REQ-014 Any other alu_op/funct SHALL decode to opcode 0000 with illegal=1; entry still transferred so downstream can trap.
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Block SHALL be a 2-entry skid buffer, states EMPTY, ONE, FULL, encoded in a registered state machine.
REQ-017 EMPTY: accept -> ONE; else stay.
REQ-018 ONE: accept without drain -> FULL (new entry to skid register); drain without accept -> EMPTY; both -> ONE with new entry in output register.
REQ-019 FULL: drain -> ONE (skid entry moves to output register); accept impossible.
REQ-020 in_ready SHALL be 1 iff state != FULL, driven from a register (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 iff state != EMPTY; opcode/a/b/illegal SHALL come directly from the output register.
REQ-022 Latency in->out SHALL be exactly 1 cycle when downstream is not stalled; throughput 1 entry/cycle.
REQ-023 Entries SHALL leave in acceptance order; no entry duplicated or lost under any in_valid/out_ready pattern.
REQ-024 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-025 flush SHALL force EMPTY next cycle, discarding any same-cycle accept; a same-cycle drain still counts as completed.

Reset
REQ-026 reset SHALL force state EMPTY, out_valid=0, in_ready=1 next cycle, opcode=0000, a=b=0, illegal=0.
REQ-027 reset SHALL take priority over flush and all handshakes, including mid-stall in FULL.

Configuration
REQ-028 Macro ALU_ISSUE_IMM_EN defined: extra inputs imm16 (16) and alu_src (1); when alu_src=1 b SHALL be imm16 sign-extended to WIDTH, else rt_data.
REQ-029 Macro undefined: imm16/alu_src ports absent; b SHALL always be rt_data.

Structure
REQ-030 Package alu_pkg SHALL hold the 4-bit opcode constants, alu_op class constants, funct constants and the state enum.
REQ-031 Decode SHALL be a combinational sub-module alu_issue_decode (alu_op, funct -> opcode, illegal); skid/FSM logic stays in alu_issue_stage.

Verification
REQ-032 Reset then alu_op=10, funct=100100, rs=0x0F, rt=0x3C, out_ready=1 -> next cycle out_valid=1, opcode=0100, a=0x0F, b=0x3C, illegal=0.
REQ-033 Stream funct 100000,100010,101010 with out_ready=0 -> after 2 accepts in_ready=0, outputs hold 0000; release out_ready -> 0000,0010,1010 delivered in order, none lost.
REQ-034 alu_op=11 or funct=000001 -> opcode=0000, illegal=1, out_valid=1.
REQ-035 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; assert reset while FULL -> all outputs at reset values.
REQ-036 With ALU_ISSUE_IMM_EN, alu_src=1, imm16=0xFFFE -> b=0xFFFFFFFE; alu_src=0 -> b=rt_data.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU issue stage shared definitions: opcodes, decoder classes,
// function codes and the skid-buffer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1010;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_RSV = 2'b11;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam int IMM_W = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream/downstream bundle of the ALU issue stage.
// Optional immediate operand fields exist only with ALU_ISSUE_IMM_EN.
interface alu_issue_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
`ifdef ALU_ISSUE_IMM_EN
  logic [15:0]      imm16;
  logic             alu_src;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             illegal;

  modport master (
    output in_valid,
    output alu_op,
    output funct,
    output rs_data,
    output rt_data,
`ifdef ALU_ISSUE_IMM_EN
    output imm16,
    output alu_src,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  opcode,
    input  a,
    input  b,
    input  illegal
  );

  modport slave (
    input  in_valid,
    input  alu_op,
    input  funct,
    input  rs_data,
    input  rt_data,
`ifdef ALU_ISSUE_IMM_EN
    input  imm16,
    input  alu_src,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output opcode,
    output a,
    output b,
    output illegal
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Combinational ALU control decoder: main-decoder class plus
// R-type function field to a 4-bit opcode and an illegal flag.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] opcode,
  output logic       illegal
);

  logic [3:0] r_op;
  logic       r_ill;

  // R-type function field lookup
  always_comb begin
    r_op  = OP_ADD;
    r_ill = 1'b0;
    unique case (funct)
      F_ADD:   r_op = OP_ADD;
      F_SUB:   r_op = OP_SUB;
      F_AND:   r_op = OP_AND;
      F_OR:    r_op = OP_OR;
      F_XOR:   r_op = OP_XOR;
      F_NOR:   r_op = OP_NOR;
      F_SLT:   r_op = OP_SLT;
      default: r_ill = 1'b1;
    endcase
  end

  // class select; unknown encodings trap downstream as add
  always_comb begin
    opcode  = OP_ADD;
    illegal = 1'b0;
    unique case (1'b1)
      (alu_op == ALUOP_MEM): opcode = OP_ADD;
      (alu_op == ALUOP_BR):  opcode = OP_SUB;
      (alu_op == ALUOP_R): begin
        opcode  = r_ill ? OP_ADD : r_op;
        illegal = r_ill;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus 2-entry skid buffer toward the ALU.
// Define ALU_ISSUE_IMM_EN to add the imm16/alu_src operand-B select.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  alu_issue_if.slave bus
);

  dec_t             dec_new;
  logic [WIDTH-1:0] b_new;

  state_t           st_q;
  state_t           st_d;
  logic             rdy_q;
  logic             acc;
  logic             drn;
  logic             ld_new;
  logic             ld_skd;
  logic             ld_fwd;

  dec_t             out_dec_q;
  logic [WIDTH-1:0] out_a_q;
  logic [WIDTH-1:0] out_b_q;
  dec_t             skd_dec_q;
  logic [WIDTH-1:0] skd_a_q;
  logic [WIDTH-1:0] skd_b_q;

  logic [3:0]       d_op;
  logic             d_ill;

  alu_issue_decode u_dec (
    .alu_op  (bus.alu_op),
    .funct   (bus.funct),
    .opcode  (d_op),
    .illegal (d_ill)
  );

  assign dec_new.opcode  = d_op;
  assign dec_new.illegal = d_ill;

`ifdef ALU_ISSUE_IMM_EN
  assign b_new = bus.alu_src
    ? {{(WIDTH-IMM_W){bus.imm16[IMM_W-1]}}, bus.imm16}
    : bus.rt_data;
`else
  assign b_new = bus.rt_data;
`endif

  assign acc = bus.in_valid & rdy_q;
  assign drn = (st_q != S_EMPTY) & bus.out_ready;

  // next state and register load selects; flush wins
  always_comb begin
    st_d   = st_q;
    ld_new = 1'b0;
    ld_skd = 1'b0;
    ld_fwd = 1'b0;
    unique case (st_q)
      S_EMPTY: begin
        if (acc) begin
          st_d   = S_ONE;
          ld_new = 1'b1;
        end
      end
      S_ONE: begin
        if (acc && drn) begin
          ld_new = 1'b1;
        end else if (acc) begin
          st_d   = S_FULL;
          ld_skd = 1'b1;
        end else if (drn) begin
          st_d   = S_EMPTY;
        end
      end
      S_FULL: begin
        if (drn) begin
          st_d   = S_ONE;
          ld_fwd = 1'b1;
        end
      end
      default: st_d = S_EMPTY;
    endcase
    if (flush) begin
      st_d   = S_EMPTY;
      ld_new = 1'b0;
      ld_skd = 1'b0;
      ld_fwd = 1'b0;
    end
  end

  // state register; in_ready precomputed from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_EMPTY;
      rdy_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      rdy_q <= (st_d != S_FULL);
    end
  end

  // output register: fresh entry or promoted skid entry
  always_ff @(posedge clk) begin
    if (reset) begin
      out_dec_q <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
    end else if (ld_new) begin
      out_dec_q <= dec_new;
      out_a_q   <= bus.rs_data;
      out_b_q   <= b_new;
    end else if (ld_fwd) begin
      out_dec_q <= skd_dec_q;
      out_a_q   <= skd_a_q;
      out_b_q   <= skd_b_q;
    end
  end

  // skid register catches the entry accepted while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      skd_dec_q <= '0;
      skd_a_q   <= '0;
      skd_b_q   <= '0;
    end else if (ld_skd) begin
      skd_dec_q <= dec_new;
      skd_a_q   <= bus.rs_data;
      skd_b_q   <= b_new;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (st_q != S_EMPTY);
  assign bus.opcode    = out_dec_q.opcode;
  assign bus.illegal   = out_dec_q.illegal;
  assign bus.a         = out_a_q;
  assign bus.b         = out_b_q;

endmodule
